data_ex_mc: RTL and testbench

Parametrised execute stage for the pipelined CPU. Provides 2-way forwarding on both operands, a registered result, an NZVC flag register with a set-flags enable, a CBZ zero bypass, and a branch-target adder. Also adds an iterative multi-cycle multiplier with a busy/stall handshake to the hazard unit. Sits between the ID/EX and EX/MEM pipeline registers.

---
 rtl/data_ex_mc.sv | 136 +++++++++++++
 tb/tb_data_ex_mc.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_ex_mc.sv
// rtl/data_ex_mc.sv - execute stage: forwarding, ALU with NZVC flags, CBZ bypass, branch adder, iterative multiplier
module data_ex_mc #(
  parameter int WIDTH        = 64,
  parameter int BITS_PER_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_offset,
  input  logic [2:0]       alu_op,
  input  logic             alu_src,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  input  logic             set_flags,
  input  logic             cbz,
  input  logic             is_mul,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [3:0]       flags,
  output logic             zero_now,
  output logic [WIDTH-1:0] branch_target
);
  localparam int N  = WIDTH / BITS_PER_CYC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [WIDTH-1:0] opa, opb_fwd, opb, bx, alu_res, partial, acc_next;
  logic [WIDTH:0]   addsub;
  logic             sub, arith, v_flag, c_flag;
  logic [3:0]       new_flags;

  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel, input logic [WIDTH-1:0] regv,
                                               input logic [WIDTH-1:0] mem, input logic [WIDTH-1:0] wb);
    case (sel)
      2'b01:   fwd_sel = wb;
      2'b10:   fwd_sel = mem;
      default: fwd_sel = regv;
    endcase
  endfunction

  // Forwarding is applied before the immediate select, so imm always wins over a forward.
  assign opa     = fwd_sel(forward_a, op_a, fwd_mem, fwd_wb);
  assign opb_fwd = fwd_sel(forward_b, op_b, fwd_mem, fwd_wb);
  assign opb     = alu_src ? imm : opb_fwd;

  assign sub    = (alu_op == 3'b011);
  assign bx     = sub ? ~opb : opb;
  assign addsub = {1'b0, opa} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    alu_res = opb;
    arith   = 1'b0;
    case (alu_op)
      3'b010, 3'b011: begin alu_res = addsub[WIDTH-1:0]; arith = 1'b1; end
      3'b100:  alu_res = opa & opb;
      3'b101:  alu_res = opa | opb;
      3'b110:  alu_res = opa ^ opb;
      default: alu_res = opb;
    endcase
  end

  assign v_flag    = arith & (opa[WIDTH-1] == bx[WIDTH-1]) & (alu_res[WIDTH-1] != opa[WIDTH-1]);
  assign c_flag    = arith & addsub[WIDTH];
  assign new_flags = {alu_res[WIDTH-1], (alu_res == '0), v_flag, c_flag};

  assign zero_now      = cbz ? (alu_res == '0) : flags[2];
  assign branch_target = pc + (br_offset << 2);

  // One radix-2^BITS_PER_CYC digit of the multiplier against the pre-shifted multiplicand.
  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end
  assign acc_next = acc + partial;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      flags        <= 4'b0000;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              mcand  <= opa;
              mplier <= opb;
              acc    <= '0;
              count  <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end else begin
              result       <= alu_res;
              result_valid <= 1'b1;
              if (set_flags) flags <= new_flags;
            end
          end
        end
        RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYC;
          mplier <= mplier >> BITS_PER_CYC;
          count  <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            result       <= acc_next;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            count        <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_ex_mc.sv
// tb/tb_data_ex_mc.sv - self-checking bench for data_ex_mc: vector table, random ALU/multiply vs reference model
module tb_data_ex_mc;
  localparam int W  = 64;
  localparam int NC = 16;

  logic         clk = 0, reset = 1, in_valid = 0, alu_src = 0, set_flags = 0, cbz = 0, is_mul = 0;
  logic [W-1:0] op_a = 0, op_b = 0, imm = 0, pc = 0, br_offset = 0, fwd_mem = 0, fwd_wb = 0;
  logic [2:0]   alu_op = 0;
  logic [1:0]   forward_a = 0, forward_b = 0;
  logic [W-1:0] result, branch_target;
  logic         result_valid, busy, zero_now;
  logic [3:0]   flags;

  int checks = 0, errors = 0;
  logic [3:0] model_flags = 4'b0000;

  data_ex_mc #(.WIDTH(W), .BITS_PER_CYC(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op_a(op_a), .op_b(op_b), .imm(imm), .pc(pc),
    .br_offset(br_offset), .alu_op(alu_op), .alu_src(alu_src), .forward_a(forward_a),
    .forward_b(forward_b), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb), .set_flags(set_flags), .cbz(cbz),
    .is_mul(is_mul), .result(result), .result_valid(result_valid), .busy(busy), .flags(flags),
    .zero_now(zero_now), .branch_target(branch_target));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, imm, mem, wb;
    logic [1:0]   fa, fb;
    logic         src;
    logic [2:0]   op;
    logic         sf, cbz;
    logic [W-1:0] er;
    logic [3:0]   ef;
    logic         ez;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference ALU from arithmetic definitions: unsigned range for C, signed range for V.
  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                  output logic [W-1:0] r, output logic [3:0] f);
    logic [W:0] wide;
    logic signed [W+1:0] s;
    logic signed [W+1:0] smax, smin;
    logic v, c;
    smax = (66'sd1 <<< (W-1)) - 66'sd1;
    smin = -(66'sd1 <<< (W-1));
    v = 0; c = 0;
    case (op)
      3'b010: begin
        wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = (wide >= (65'd1 << W));
        s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}); v = (s > smax) || (s < smin);
      end
      3'b011: begin
        r = a - b; c = (a >= b);
        s = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b}); v = (s > smax) || (s < smin);
      end
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      default: r = b;
    endcase
    f = {r[W-1], r == 0, v, c};
  endfunction

  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] rv, input logic [W-1:0] mem,
                                        input logic [W-1:0] wb);
    if (s == 2'b01) return wb;
    if (s == 2'b10) return mem;
    return rv;
  endfunction

  task automatic drive(input vec_t v);
    op_a = v.a; op_b = v.b; imm = v.imm; fwd_mem = v.mem; fwd_wb = v.wb;
    forward_a = v.fa; forward_b = v.fb; alu_src = v.src; alu_op = v.op; set_flags = v.sf; cbz = v.cbz;
  endtask

  task automatic run_alu(input vec_t v, input string nm);
    drive(v);
    is_mul = 0; in_valid = 1;
    #1;
    chk({nm, " zero_now"}, zero_now, v.ez);
    tick();
    in_valid = 0;
    chk({nm, " result_valid"}, result_valid, 1);
    chk({nm, " result"}, result, v.er);
    chk({nm, " flags"}, flags, v.ef);
  endtask

  task automatic run_mul(input vec_t v, input bit noise, input string nm);
    logic [2*W-1:0] p;
    logic [W-1:0] ea, eb;
    int cnt, guard;
    ea = pick(v.fa, v.a, v.mem, v.wb);
    eb = v.src ? v.imm : pick(v.fb, v.b, v.mem, v.wb);
    p = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
    drive(v);
    is_mul = 1; in_valid = 1;
    tick();
    in_valid = 0; is_mul = 0;
    cnt = 0; guard = 0;
    while (busy && guard < 40) begin
      cnt++;
      chk({nm, " no early result_valid"}, result_valid, 0);
      if (noise && cnt == 2) begin
        op_a = 64'd1; op_b = 64'd1; alu_op = 3'b010; set_flags = 1; in_valid = 1;
      end
      if (noise && cnt == 5) in_valid = 0;
      tick();
      guard++;
    end
    chk({nm, " busy cycles"}, cnt, NC);
    chk({nm, " result_valid"}, result_valid, 1);
    chk({nm, " busy low at result"}, busy, 0);
    chk({nm, " result"}, result, p[W-1:0]);
    chk({nm, " flags unchanged"}, flags, model_flags);
  endtask

  initial begin
    vec_t v;
    logic [W-1:0] r;
    logic [3:0] f;
    bit seen;

    tbl[0]  = '{64'h2AA, 64'h155, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0, 64'h3FF, 4'b0000, 0};
    tbl[1]  = '{64'd5, 64'd5, 0, 0, 0, 2'b00, 2'b00, 0, 3'b011, 1, 1, 64'd0, 4'b0101, 1};
    tbl[2]  = '{64'd3, 64'd4, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, 1, 64'd7, 4'b0101, 0};
    tbl[3]  = '{64'd10, 64'd0, 64'd1, 64'd7, 64'd20, 2'b01, 2'b10, 1, 3'b010, 0, 0, 64'd21, 4'b0101, 1};
    tbl[4]  = '{64'd10, 64'd0, 64'd1, 64'd7, 64'd20, 2'b01, 2'b10, 0, 3'b010, 0, 0, 64'd27, 4'b0101, 1};
    tbl[5]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 1, 1,
                64'h8000_0000_0000_0000, 4'b1010, 0};
    tbl[6]  = '{64'hF0F0, 64'hFF00, 0, 0, 0, 2'b00, 2'b00, 0, 3'b100, 1, 0, 64'hF000, 4'b0000, 0};
    tbl[7]  = '{64'd1, 64'd1, 0, 0, 0, 2'b00, 2'b00, 0, 3'b110, 1, 1, 64'd0, 4'b0100, 1};
    tbl[8]  = '{64'd9, 64'h8000_0000_0000_0000, 0, 0, 0, 2'b00, 2'b00, 0, 3'b001, 1, 0,
                64'h8000_0000_0000_0000, 4'b1000, 1};
    tbl[9]  = '{64'd3, 64'd5, 0, 0, 0, 2'b00, 2'b00, 0, 3'b011, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 0};
    tbl[10] = '{64'd1, 64'd2, 0, 64'd99, 0, 2'b00, 2'b11, 0, 3'b010, 0, 0, 64'd3, 4'b1000, 0};

    tick(); tick();
    chk("reset result", result, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset flags", flags, 0);
    @(negedge clk); reset = 0;
    tick();

    foreach (tbl[i]) begin
      run_alu(tbl[i], $sformatf("vec%0d", i));
      model_flags = tbl[i].ef;
    end
    tick();
    chk("result_valid one cycle", result_valid, 0);
    chk("result holds", result, 64'd3);

    // Test plan multiply with an ignored mid-run add
    v = '{64'h1234, 64'h10, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0, 0, 0, 0};
    run_mul(v, 1, "mul plan");

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ea, eb;
      v.a = {$urandom, $urandom}; v.b = {$urandom, $urandom}; v.imm = {$urandom, $urandom};
      v.mem = {$urandom, $urandom}; v.wb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) v.b = v.a;
      if ($urandom_range(0, 7) == 0) begin v.a = {$urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 32'hFFFF_FFFF}; end
      v.fa = 2'($urandom); v.fb = 2'($urandom); v.src = 1'($urandom); v.op = 3'($urandom);
      v.sf = 1'($urandom); v.cbz = 1'($urandom);
      ea = pick(v.fa, v.a, v.mem, v.wb);
      eb = v.src ? v.imm : pick(v.fb, v.b, v.mem, v.wb);
      if ($urandom_range(0, 24) == 0) begin
        run_mul(v, 0, "rand mul");
      end else begin
        ref_alu(ea, eb, v.op, r, f);
        v.er = r;
        v.ez = v.cbz ? (r == 0) : model_flags[2];
        if (v.sf) model_flags = f;
        v.ef = model_flags;
        run_alu(v, "rand alu");
      end
    end

    // Reset five cycles into a multiply
    v = '{64'h55, 64'h77, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 1, 0, 0, 0, 0};
    drive(v); is_mul = 1; in_valid = 1;
    tick();
    in_valid = 0; is_mul = 0;
    repeat (5) tick();
    chk("busy before abort", busy, 1);
    reset = 1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort result_valid", result_valid, 0);
    chk("abort flags", flags, 0);
    @(negedge clk); reset = 0;
    model_flags = 0;
    seen = 0;
    repeat (25) begin
      tick();
      if (result_valid) seen = 1;
    end
    chk("no result after abort", seen, 0);

    pc = 64'h100; br_offset = -64'sd2; #1;
    chk("branch_target", branch_target, 64'hF8);
    for (int i = 0; i < 8; i++) begin
      pc = {$urandom, $urandom}; br_offset = {$urandom, $urandom}; #1;
      chk("branch_target rand", branch_target, pc + br_offset * 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
